// File: rtl/reg_file_32.sv
// 32 x 32-bit register file: two combinational read ports, one write-back port, r0 hard-wired to zero.
// Latency: reads are zero-cycle; a write lands at the next rising edge (same-cycle visible when BYPASS=1); trap lags by one cycle.
// Backpressure: none; every cycle's write-back request is either committed, discarded (r0) or trapped (overflow).
module reg_file_32 #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        reg_write,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    input  logic        overflow,
    output logic        trap,
    output logic [15:0] wr_count
);

    // Forwarding is a build-time choice; folding it into one bit keeps the read muxes simple.
    localparam logic FWD_EN = (BYPASS != 0);

    // Storage. Entry 0 exists only so the array is naturally indexed; it is
    // cleared by reset, never written, and masked on read regardless.
    logic [31:0] regs [0:31];

    // Write-back classification for the current cycle.
    logic        wr_req;      // write-back requested at all
    logic        wr_suppress; // ALU flagged overflow: drop it and raise trap
    logic        wr_to_zero;  // destination is r0: silently drop
    logic        wr_commit;   // this request will update the array at the edge

    // Read-port forwarding hits.
    logic        rs_fwd;
    logic        rt_fwd;

    // Registered outputs.
    logic        trap_q;
    logic [15:0] wr_count_q;

    // Decide what happens to this cycle's write-back request. Reset blocks the
    // commit so a write coincident with reset is neither stored nor counted.
    always_comb begin
        wr_req      = reg_write;
        wr_suppress = reg_write & overflow;
        wr_to_zero  = (rd_addr == 5'd0);
        wr_commit   = rst_n & wr_req & ~overflow & ~wr_to_zero;
    end

    // Forward only genuine commits, so trapped or r0 writes never leak onto a read port.
    always_comb begin
        rs_fwd = FWD_EN & wr_commit & (rd_addr == rs_addr);
        rt_fwd = FWD_EN & wr_commit & (rd_addr == rt_addr);
    end

    // Register array: clear everything on reset, otherwise take committed writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (wr_commit) begin
            regs[rd_addr] <= rd_data;
        end
    end

    // Trap is the one-cycle-late echo of a suppressed write; consecutive suppressions keep it high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= wr_suppress;
        end
    end

    // Committed-write counter; 16-bit arithmetic wraps ffff -> 0000 on its own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count_q <= 16'h0000;
        end else if (wr_commit) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    // Read port A: zero while in reset or for r0, forwarded data on a hit, else the array.
    // Both ports share identical selection logic so equal addresses always agree.
    always_comb begin
        rs_data = regs[rs_addr];
        if (!rst_n || (rs_addr == 5'd0)) begin
            rs_data = 32'h0;
        end else if (rs_fwd) begin
            rs_data = rd_data;
        end
    end

    // Read port B: same selection as port A.
    always_comb begin
        rt_data = regs[rt_addr];
        if (!rst_n || (rt_addr == 5'd0)) begin
            rt_data = 32'h0;
        end else if (rt_fwd) begin
            rt_data = rd_data;
        end
    end

    assign trap     = trap_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_32.sv
// Bench for reg_file_32: drives one stimulus stream into a forwarding and a non-forwarding instance.
// A high-level model is compared against both instances every cycle; literal checks pin the model.
module tb_reg_file_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        reg_write, overflow;
    logic [31:0] rd_data;

    logic [31:0] rs_b1, rt_b1, rs_b0, rt_b0;
    logic        trap_b1, trap_b0;
    logic [15:0] cnt_b1, cnt_b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_32 #(.BYPASS(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_b1), .rt_data(rt_b1), .reg_write(reg_write), .rd_addr(rd_addr),
        .rd_data(rd_data), .overflow(overflow), .trap(trap_b1), .wr_count(cnt_b1)
    );

    reg_file_32 #(.BYPASS(0)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_b0), .rt_data(rt_b0), .reg_write(reg_write), .rd_addr(rd_addr),
        .rd_data(rd_data), .overflow(overflow), .trap(trap_b0), .wr_count(cnt_b0)
    );

    // Reference model: architectural register contents, commit count, trap.
    logic [31:0] m_mem [0:31];
    logic [15:0] m_cnt;
    logic        m_trap;
    logic        m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read port must show right now, from the architectural rules.
    function automatic logic [31:0] exp_read(input logic fwd, input logic [4:0] a);
        if (!rst_n) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (fwd && reg_write && !overflow && rd_addr == a) return rd_data;
        return m_mem[a];
    endfunction

    // Model state update at each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= 32'h0;
            m_cnt   <= 16'h0;
            m_trap  <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            m_trap <= reg_write && overflow;
            if (reg_write && !overflow && rd_addr != 5'd0) begin
                m_mem[rd_addr] <= rd_data;
                m_cnt          <= m_cnt + 16'd1;
            end
        end
    end

    // Every-cycle comparison, mid-cycle, once the model has seen a reset edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_rs_b1",   rs_b1,           exp_read(1'b1, rs_addr));
            check("cyc_rt_b1",   rt_b1,           exp_read(1'b1, rt_addr));
            check("cyc_rs_b0",   rs_b0,           exp_read(1'b0, rs_addr));
            check("cyc_rt_b0",   rt_b0,           exp_read(1'b0, rt_addr));
            check("cyc_trap_b1", 32'(trap_b1),    32'(m_trap));
            check("cyc_trap_b0", 32'(trap_b0),    32'(m_trap));
            check("cyc_cnt_b1",  32'(cnt_b1),     32'(m_cnt));
            check("cyc_cnt_b0",  32'(cnt_b0),     32'(m_cnt));
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [4:0] rd,
                         input logic [31:0] d, input logic ov,
                         input logic [4:0] ra, input logic [4:0] rb);
        rst_n     = rst;
        reg_write = we;
        rd_addr   = rd;
        rd_data   = d;
        overflow  = ov;
        rs_addr   = ra;
        rt_addr   = rb;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held over two edges with a write pending.
        drive(1'b0, 1'b1, 5'd5, 32'hdead_beef, 1'b0, 5'd5, 5'd5);
        #3;
        check("rst_bypass_off_b1", rs_b1, 32'h0);
        check("rst_read_b0", rt_b0, 32'h0);
        tick;
        tick;
        check("rst_cnt", 32'(cnt_b1), 32'h0);
        check("rst_trap", 32'(trap_b0), 32'h0);

        // Write 1 to r8, read r8 / r0.
        drive(1'b1, 1'b1, 5'd8, 32'h1, 1'b0, 5'd8, 5'd0);
        #3;
        check("r8_fwd_b1", rs_b1, 32'h1);
        check("r8_old_b0", rs_b0, 32'h0);
        check("r0_rt_b1", rt_b1, 32'h0);
        tick;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 5'd0);
        #3;
        check("r8_read_b0", rs_b0, 32'h1);
        check("r8_read_b1", rs_b1, 32'h1);
        check("r8_rt_zero", rt_b0, 32'h0);
        check("r8_cnt", 32'(cnt_b0), 32'd1);

        // Write to r0 is discarded and not forwarded.
        drive(1'b1, 1'b1, 5'd0, 32'hffff_ffff, 1'b0, 5'd0, 5'd0);
        #3;
        check("r0_nofwd", rs_b1, 32'h0);
        tick;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        #3;
        check("r0_read", rs_b0, 32'h0);
        check("r0_cnt", 32'(cnt_b1), 32'd1);
        check("r0_trap", 32'(trap_b1), 32'h0);

        // Overflow-suppressed write to r9.
        drive(1'b1, 1'b1, 5'd9, 32'h0000_1234, 1'b0, 5'd9, 5'd9);
        tick;
        drive(1'b1, 1'b1, 5'd9, 32'h7fff_ffff, 1'b1, 5'd9, 5'd9);
        #3;
        check("ovf_nofwd", rs_b1, 32'h0000_1234);
        tick;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9);
        #3;
        check("ovf_trap_b1", 32'(trap_b1), 32'h1);
        check("ovf_trap_b0", 32'(trap_b0), 32'h1);
        check("ovf_r9_kept", rt_b0, 32'h0000_1234);
        check("ovf_cnt", 32'(cnt_b1), 32'd2);
        tick;
        #3;
        check("ovf_trap_clear", 32'(trap_b1), 32'h0);

        // Back-to-back suppressed writes keep trap high.
        drive(1'b1, 1'b1, 5'd3, 32'h0000_00aa, 1'b1, 5'd3, 5'd3);
        tick;
        drive(1'b1, 1'b1, 5'd3, 32'h0000_00bb, 1'b1, 5'd3, 5'd3);
        #3;
        check("b2b_trap_1", 32'(trap_b1), 32'h1);
        tick;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
        #3;
        check("b2b_trap_2", 32'(trap_b0), 32'h1);
        tick;
        #3;
        check("b2b_trap_end", 32'(trap_b1), 32'h0);
        check("b2b_r3_zero", rs_b1, 32'h0);

        // Same-cycle read of a committing write to r10 on both ports.
        drive(1'b1, 1'b1, 5'd10, 32'h5, 1'b0, 5'd10, 5'd10);
        tick;
        drive(1'b1, 1'b1, 5'd10, 32'hc, 1'b0, 5'd10, 5'd10);
        #3;
        check("byp_rs_b1", rs_b1, 32'hc);
        check("byp_rt_b1", rt_b1, 32'hc);
        check("nobyp_rs_b0", rs_b0, 32'h5);
        check("nobyp_rt_b0", rt_b0, 32'h5);
        tick;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 5'd10);
        #3;
        check("nobyp_next_rs", rs_b0, 32'hc);
        check("nobyp_next_rt", rt_b0, 32'hc);
        check("byp_cnt", 32'(cnt_b0), 32'd4);

        // Fill r1..r31, then reset coincident with a write to r5.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'hffff_fff9, 1'b0, 5'(i), 5'd0);
            tick;
        end
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd31);
        #3;
        check("fill_r5", rs_b0, 32'hffff_fff9);
        check("fill_r31", rt_b1, 32'hffff_fff9);
        check("fill_cnt", 32'(cnt_b1), 32'd35);
        tick;
        drive(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd5, 5'd5);
        #3;
        check("rstw_nofwd", rs_b1, 32'h0);
        tick;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(i));
            #3;
            check("clr_rs_b0", rs_b0, 32'h0);
            check("clr_rt_b1", rt_b1, 32'h0);
            tick;
        end
        check("clr_cnt", 32'(cnt_b0), 32'h0);

        // Counter wrap: 65535 commits, then one more.
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b1, 5'd1, 32'(i), 1'b0, 5'd2, 5'd1);
            tick;
        end
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd0);
        #3;
        check("wrap_pre_b1", 32'(cnt_b1), 32'h0000_ffff);
        check("wrap_pre_b0", 32'(cnt_b0), 32'h0000_ffff);
        check("wrap_r1", rs_b0, 32'h0000_fffe);
        drive(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7);
        #3;
        check("wrap_fwd", rt_b1, 32'h77);
        tick;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7);
        #3;
        check("wrap_b1", 32'(cnt_b1), 32'h0);
        check("wrap_b0", 32'(cnt_b0), 32'h0);
        check("wrap_r7", rs_b0, 32'h77);
        tick;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
